// File: rtl/odd_parity_checker.sv
// ============================================================================
// odd_parity_checker: serial odd-parity frame receiver with valid/ready output
// and running frame/error counters.  Rev 1.0
// ============================================================================
`default_nettype none

module odd_parity_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic              in_bit_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_err_o,
  input  logic              out_ready_i,
  input  logic              clr_count_i,
  output logic [CNT_W-1:0]  frame_count_o,
  output logic [CNT_W-1:0]  err_count_o
);

  localparam int BC_W = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                frame_done;
  logic                frame_bad;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      RECV: begin
        if (in_valid_i) begin
          if (bit_cnt_q == BC_W'(DATA_W)) begin
            // Odd parity: an even total count of ones is an error.
            frame_done = 1'b1;
            frame_bad  = ~(^shift_q ^ in_bit_i);
            out_data_d = shift_q;
            out_err_d  = frame_bad;
            bit_cnt_d  = '0;
            state_d    = HOLD;
          end else begin
            for (int i = 0; i < DATA_W; i++) begin
              if (bit_cnt_q == BC_W'(i)) shift_d[i] = in_bit_i;
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr_count_i) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (frame_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RECV;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready_o    = (state_q == RECV);
  assign out_valid_o   = (state_q == HOLD);
  assign out_data_o    = out_data_q;
  assign out_err_o     = out_err_q;
  assign frame_count_o = frame_cnt_q;
  assign err_count_o   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_odd_parity_checker.sv
// ============================================================================
// tb_odd_parity_checker: randomized self-checking bench driving a 16-bit and a
// 2-bit counter instance from the same serial stimulus.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_odd_parity_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       clr_count;

  logic       in_ready_a, out_valid_a, out_err_a;
  logic [7:0] out_data_a;
  logic [15:0] frame_cnt_a, err_cnt_a;

  logic       in_ready_b, out_valid_b, out_err_b;
  logic [7:0] out_data_b;
  logic [1:0] frame_cnt_b, err_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: totals since last reset/clear, reduced per counter width.
  int frames_tot = 0;
  int errs_tot   = 0;

  odd_parity_checker #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_bit_i(in_bit), .in_ready_o(in_ready_a),
    .out_valid_o(out_valid_a), .out_data_o(out_data_a), .out_err_o(out_err_a),
    .out_ready_i(out_ready), .clr_count_i(clr_count),
    .frame_count_o(frame_cnt_a), .err_count_o(err_cnt_a)
  );

  odd_parity_checker #(.DATA_W(8), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_bit_i(in_bit), .in_ready_o(in_ready_b),
    .out_valid_o(out_valid_b), .out_data_o(out_data_b), .out_err_o(out_err_b),
    .out_ready_i(out_ready), .clr_count_i(clr_count),
    .frame_count_o(frame_cnt_b), .err_count_o(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters();
    check("frame_cnt16", 32'(frame_cnt_a), frames_tot % 65536);
    check("err_cnt16",   32'(err_cnt_a),   (errs_tot > 65535) ? 65535 : errs_tot);
    check("frame_cnt2",  32'(frame_cnt_b), frames_tot % 4);
    check("err_cnt2",    32'(err_cnt_b),   (errs_tot > 3) ? 3 : errs_tot);
  endtask

  task automatic check_frame(input logic [7:0] d, input logic p);
    logic exp_err;
    exp_err = (($countones(d) + int'(p)) % 2) == 0;
    check("out_valid", {30'b0, out_valid_a, out_valid_b}, 32'h3);
    check("out_data",  {16'b0, out_data_a, out_data_b}, {16'b0, d, d});
    check("out_err",   {30'b0, out_err_a, out_err_b}, {30'b0, exp_err, exp_err});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frames_tot = 0;
    errs_tot   = 0;
  endtask

  // Sends 8 data bits LSB first, then p; optional random gaps and clear on parity.
  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps, input bit clr_on_p);
    logic [8:0] bits;
    bits = {p, d};
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      check("in_ready", {31'b0, in_ready_a & in_ready_b}, 32'h1);
      if (i == 8) check("pre_valid", {31'b0, out_valid_a | out_valid_b}, 32'h0);
      in_valid  = 1'b1;
      in_bit    = bits[i];
      clr_count = clr_on_p && (i == 8);
      tick();
    end
    in_valid  = 1'b0;
    clr_count = 1'b0;
    if (clr_on_p) begin
      frames_tot = 0;
      errs_tot   = 0;
    end else begin
      frames_tot++;
      if ((($countones(d) + int'(p)) % 2) == 0) errs_tot++;
    end
    check_frame(d, p);
    check_counters();
  endtask

  // Stalls the consumer for 'stall' cycles while upstream pushes ignored bits.
  task automatic release_frame(input int stall);
    logic [7:0] d;
    logic       e;
    d = out_data_a;
    e = out_err_a;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_bit    = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", {31'b0, out_valid_a}, 32'h1);
      check("hold_data",  {23'b0, out_data_a, out_err_a}, {23'b0, d, e});
      check("hold_ready", {31'b0, in_ready_a}, 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_valid", {30'b0, out_valid_a, out_valid_b}, 32'h0);
    check("rel_ready", {30'b0, in_ready_a, in_ready_b}, 32'h3);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    repeat (2) tick();
    apply_reset();
    check("rst_valid", {31'b0, out_valid_a}, 32'h0);
    check("rst_ready", {31'b0, in_ready_a}, 32'h1);
    check("rst_data",  {23'b0, out_data_a, out_err_a}, 32'h0);
    check_counters();

    // Good frame, then a bad one and two good ones.
    send_frame(8'hEA, 1'b0, 1'b0, 1'b0); release_frame(0);
    send_frame(8'hEA, 1'b1, 1'b0, 1'b0); release_frame(0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0); release_frame(0);
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0); release_frame(0);

    // Consumer stall.
    send_frame(8'h5C, 1'b1, 1'b0, 1'b0); release_frame(5);

    // Gaps between bits.
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0); release_frame(1);

    // Reset mid-frame discards the partial word.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; tick();
    end
    in_valid = 1'b0;
    apply_reset();
    send_frame(8'h8A, 1'b0, 1'b0, 1'b0); release_frame(0);

    // Reset while holding a frame drops out_valid.
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    apply_reset();
    check("rst_hold_valid", {30'b0, out_valid_a, out_valid_b}, 32'h0);
    check("rst_hold_ready", {30'b0, in_ready_a, in_ready_b}, 32'h3);
    check_counters();

    // Saturation/wrap on the narrow counters, then clear on a parity cycle.
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b1, 1'b0, 1'b0); release_frame(0);
    end
    send_frame(8'h03, 1'b0, 1'b0, 1'b1); release_frame(0);

    // Randomized frames with gaps and stalls.
    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      release_frame(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
